// File: rtl/rst_seq_xil7series_if.sv
// rtl/rst_seq_xil7series_if.sv - lock/request inputs and sequenced reset outputs of the reset sequencer
interface rst_seq_xil7series_if;
  logic       pll_locked_i;
  logic       sw_rst_req_i;
  logic       rst_por_n_o;
  logic       rst_sys_n_o;
  logic       rst_periph_n_o;
  logic [2:0] seq_state_o;
  logic [1:0] rst_cause_o;

  modport master (
    input  pll_locked_i,
    input  sw_rst_req_i,
    output rst_por_n_o,
    output rst_sys_n_o,
    output rst_periph_n_o,
    output seq_state_o,
    output rst_cause_o
  );

  modport slave (
    output pll_locked_i,
    output sw_rst_req_i,
    input  rst_por_n_o,
    input  rst_sys_n_o,
    input  rst_periph_n_o,
    input  seq_state_o,
    input  rst_cause_o
  );
endinterface

// File: rtl/rst_seq_xil7series.sv
// rtl/rst_seq_xil7series.sv - PLL-lock filtered, stretched, ordered POR/system/peripheral reset sequencer
module rst_seq_xil7series #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 8,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4
) (
  input  logic                 io_clk_buf,
  input  logic                 IO_RST_N,
  rst_seq_xil7series_if.master bus
);

  localparam int MAX_AB = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int MAX_C  = (MAX_AB > LOCK_FILTER) ? MAX_AB : LOCK_FILTER;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] FILT_MAX     = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);

  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  typedef enum logic [2:0] {
    ST_RESET     = 3'b000,
    ST_WAIT_LOCK = 3'b001,
    ST_STRETCH   = 3'b010,
    ST_REL_POR   = 3'b011,
    ST_REL_SYS   = 3'b100,
    ST_RUN       = 3'b101,
    ST_SW_RST    = 3'b110
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_filt;
  logic [CW-1:0]          r_cnt;
  state_t                 r_state;
  logic [1:0]             r_cause;
  logic                   r_por_n;
  logic                   r_sys_n;
  logic                   r_periph_n;

  logic                   w_lock_s;
  logic                   w_lock_ok;
  state_t                 w_state_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [1:0]             w_cause_nxt;
  logic                   w_por_nxt;
  logic                   w_sys_nxt;
  logic                   w_periph_nxt;

  always_ff @(posedge io_clk_buf or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_locked_i};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Any single low sample restarts the filter; lock is trusted only after an unbroken run.
  always_ff @(posedge io_clk_buf or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      r_filt <= '0;
    end else if (!w_lock_s) begin
      r_filt <= '0;
    end else if (r_filt != FILT_MAX) begin
      r_filt <= r_filt + 1'b1;
    end
  end

  assign w_lock_ok = (r_filt == FILT_MAX);

  always_ff @(posedge io_clk_buf or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      r_state    <= ST_RESET;
      r_cnt      <= '0;
      r_cause    <= CAUSE_EXT;
      r_por_n    <= 1'b0;
      r_sys_n    <= 1'b0;
      r_periph_n <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cause    <= w_cause_nxt;
      r_por_n    <= w_por_nxt;
      r_sys_n    <= w_sys_nxt;
      r_periph_n <= w_periph_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;

    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_ok) begin
          w_state_nxt = ST_STRETCH;
          w_cnt_nxt   = '0;
        end
      end
      ST_STRETCH: begin
        if (r_cnt == STRETCH_LAST) begin
          w_state_nxt = ST_REL_POR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_REL_POR: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_REL_SYS;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_REL_SYS: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.sw_rst_req_i) begin
          w_state_nxt = ST_SW_RST;
          w_cnt_nxt   = '0;
          w_cause_nxt = CAUSE_SW;
        end
      end
      ST_SW_RST: begin
        if (r_cnt == STRETCH_LAST) begin
          w_state_nxt = ST_REL_POR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_cnt_nxt   = '0;
      end
    endcase

    // Lock loss overrides whatever the state decided, including a software request.
    if ((r_state != ST_RESET) && (r_state != ST_WAIT_LOCK) && !w_lock_ok) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_cause_nxt = CAUSE_LOCK;
    end

    w_por_nxt    = (w_state_nxt == ST_REL_POR) || (w_state_nxt == ST_REL_SYS) ||
                   (w_state_nxt == ST_RUN)     || (w_state_nxt == ST_SW_RST);
    w_sys_nxt    = (w_state_nxt == ST_REL_SYS) || (w_state_nxt == ST_RUN);
    w_periph_nxt = (w_state_nxt == ST_RUN);
  end

  assign bus.rst_por_n_o    = r_por_n;
  assign bus.rst_sys_n_o    = r_sys_n;
  assign bus.rst_periph_n_o = r_periph_n;
  assign bus.seq_state_o    = r_state;
  assign bus.rst_cause_o    = r_cause;

endmodule

// File: tb/tb_rst_seq_xil7series.sv
// tb/tb_rst_seq_xil7series.sv - timeline-model and directed-vector bench for the reset sequencer
module tb_rst_seq_xil7series;
  localparam int SS = 2;
  localparam int LF = 8;
  localparam int SC = 16;
  localparam int SG = 4;

  localparam int M_PRE   = 0;
  localparam int M_IDLE  = 1;
  localparam int M_SEQ   = 2;
  localparam int M_SWSEQ = 3;

  logic io_clk_buf = 1'b0;
  logic IO_RST_N;
  always #5 io_clk_buf = ~io_clk_buf;

  rst_seq_xil7series_if bus ();

  rst_seq_xil7series #(
    .SYNC_STAGES(SS), .LOCK_FILTER(LF), .STRETCH_CYCLES(SC), .STAGE_GAP(SG)
  ) dut (
    .io_clk_buf(io_clk_buf),
    .IO_RST_N  (IO_RST_N),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // Model: edges since reset release, pll sample history, and the edge at which the
  // current release sequence (full or software) began.
  int n     = 0;
  int mode  = M_PRE;
  int t0    = 0;
  int cause = 0;
  bit hist[$];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  function automatic void model_reset();
    n     = 0;
    mode  = M_PRE;
    t0    = 0;
    cause = 0;
    hist.delete();
    for (int k = 0; k < 16; k++) hist.push_back(1'b0);
  endfunction

  function automatic bit trusted();
    for (int k = SS + 1; k <= SS + LF; k++) begin
      if (!hist[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge io_clk_buf) begin
    bit prev_run;
    if (!IO_RST_N) begin
      model_reset();
    end else begin
      prev_run = (mode == M_SEQ || mode == M_SWSEQ) && ((n - t0) >= SC + 2 * SG);
      n++;
      hist.push_front(bus.pll_locked_i);
      void'(hist.pop_back());
      if (mode == M_PRE) begin
        mode = M_IDLE;
      end else if (mode == M_IDLE) begin
        if (trusted()) begin
          mode = M_SEQ;
          t0   = n;
        end
      end else if (!trusted()) begin
        mode  = M_IDLE;
        cause = 1;
      end else if (prev_run && bus.sw_rst_req_i) begin
        mode  = M_SWSEQ;
        t0    = n;
        cause = 2;
      end
    end
  end

  always @(negedge io_clk_buf) begin
    int d, e_st, e_por, e_sys, e_per, e_cause;
    if (armed) begin
      e_st = 0; e_por = 0; e_sys = 0; e_per = 0; e_cause = 0;
      if (IO_RST_N) begin
        e_cause = cause;
        if (mode == M_IDLE) begin
          e_st = 1;
        end else if (mode == M_SEQ || mode == M_SWSEQ) begin
          d     = n - t0;
          e_por = (mode == M_SWSEQ || d >= SC) ? 1 : 0;
          e_sys = (d >= SC + SG) ? 1 : 0;
          e_per = (d >= SC + 2 * SG) ? 1 : 0;
          if (d >= SC + 2 * SG)  e_st = 5;
          else if (d >= SC + SG) e_st = 4;
          else if (d >= SC)      e_st = 3;
          else                   e_st = (mode == M_SWSEQ) ? 6 : 2;
        end
      end
      check("model_por",    3'(bus.rst_por_n_o),    3'(e_por));
      check("model_sys",    3'(bus.rst_sys_n_o),    3'(e_sys));
      check("model_periph", 3'(bus.rst_periph_n_o), 3'(e_per));
      check("model_state",  bus.seq_state_o,        3'(e_st));
      check("model_cause",  3'(bus.rst_cause_o),    3'(e_cause));
    end
  end

  task automatic wait_edge(input int k);
    int guard = 0;
    while (n < k && guard < 1000) begin
      @(negedge io_clk_buf);
      guard++;
    end
    total++;
    if (n != k) begin
      bad++;
      $display("FAIL wait_edge: reached edge %0d want %0d", n, k);
    end
  endtask

  task automatic lit(input string name, input int k, input logic por, input logic sys,
                     input logic per, input logic [2:0] st, input logic [1:0] c);
    wait_edge(k);
    check({name, "_por"},    3'(bus.rst_por_n_o),    3'(por));
    check({name, "_sys"},    3'(bus.rst_sys_n_o),    3'(sys));
    check({name, "_periph"}, 3'(bus.rst_periph_n_o), 3'(per));
    check({name, "_state"},  bus.seq_state_o,        st);
    check({name, "_cause"},  3'(bus.rst_cause_o),    3'(c));
  endtask

  initial begin
    model_reset();
    IO_RST_N         = 1'b1;
    bus.pll_locked_i = 1'b1;
    bus.sw_rst_req_i = 1'b0;
    #1 IO_RST_N = 1'b0;
    armed = 1'b1;
    repeat (3) @(negedge io_clk_buf);
    check("reset_por",   3'(bus.rst_por_n_o), 3'd0);
    check("reset_state", bus.seq_state_o,     3'd0);
    check("reset_cause", 3'(bus.rst_cause_o), 3'd0);
    #1 IO_RST_N = 1'b1;

    lit("boot26", 26, 0, 0, 0, 3'd2, 2'd0);
    lit("boot27", 27, 1, 0, 0, 3'd3, 2'd0);
    lit("boot30", 30, 1, 0, 0, 3'd3, 2'd0);
    lit("boot31", 31, 1, 1, 0, 3'd4, 2'd0);
    lit("boot34", 34, 1, 1, 0, 3'd4, 2'd0);
    lit("boot35", 35, 1, 1, 1, 3'd5, 2'd0);

    wait_edge(40); #1 bus.sw_rst_req_i = 1'b1;
    lit("sw41", 41, 1, 0, 0, 3'd6, 2'd2); #1 bus.sw_rst_req_i = 1'b0;
    lit("sw60", 60, 1, 0, 0, 3'd3, 2'd2);
    lit("sw61", 61, 1, 1, 0, 3'd4, 2'd2);
    lit("sw64", 64, 1, 1, 0, 3'd4, 2'd2);
    lit("sw65", 65, 1, 1, 1, 3'd5, 2'd2);

    wait_edge(70); #1 bus.pll_locked_i = 1'b0;
    lit("loss73", 73, 1, 1, 1, 3'd5, 2'd2);
    lit("loss74", 74, 0, 0, 0, 3'd1, 2'd1);
    wait_edge(80); #1 bus.pll_locked_i = 1'b1;
    lit("relock90",  90,  0, 0, 0, 3'd1, 2'd1);
    lit("relock91",  91,  0, 0, 0, 3'd2, 2'd1);
    lit("relock106", 106, 0, 0, 0, 3'd2, 2'd1);
    lit("relock107", 107, 1, 0, 0, 3'd3, 2'd1);
    lit("relock111", 111, 1, 1, 0, 3'd4, 2'd1);
    lit("relock115", 115, 1, 1, 1, 3'd5, 2'd1);

    wait_edge(120); #1 bus.pll_locked_i = 1'b0;
    lit("loss124", 124, 0, 0, 0, 3'd1, 2'd1);
    wait_edge(130); #1 bus.pll_locked_i = 1'b1;
    wait_edge(135); #1 bus.pll_locked_i = 1'b0;
    wait_edge(140); #1 bus.pll_locked_i = 1'b1;
    lit("glitch145", 145, 0, 0, 0, 3'd1, 2'd1);
    lit("glitch150", 150, 0, 0, 0, 3'd1, 2'd1);
    lit("glitch151", 151, 0, 0, 0, 3'd2, 2'd1);

    wait_edge(154); #1 bus.sw_rst_req_i = 1'b1;
    lit("ign155", 155, 0, 0, 0, 3'd2, 2'd1); #1 bus.sw_rst_req_i = 1'b0;
    lit("ign166", 166, 0, 0, 0, 3'd2, 2'd1);
    lit("ign167", 167, 1, 0, 0, 3'd3, 2'd1);
    lit("ign171", 171, 1, 1, 0, 3'd4, 2'd1); #1 bus.sw_rst_req_i = 1'b1;
    lit("ign172", 172, 1, 1, 0, 3'd4, 2'd1); #1 bus.sw_rst_req_i = 1'b0;
    lit("ign174", 174, 1, 1, 0, 3'd4, 2'd1);
    lit("ign175", 175, 1, 1, 1, 3'd5, 2'd1);

    wait_edge(179); #1 bus.sw_rst_req_i = 1'b1;
    lit("sw180", 180, 1, 0, 0, 3'd6, 2'd2); #1 bus.sw_rst_req_i = 1'b0;
    lit("sw196", 196, 1, 0, 0, 3'd3, 2'd2);
    lit("sw200", 200, 1, 1, 0, 3'd4, 2'd2);
    wait_edge(201); #1 IO_RST_N = 1'b0;
    #2;
    check("abort_por",    3'(bus.rst_por_n_o),    3'd0);
    check("abort_sys",    3'(bus.rst_sys_n_o),    3'd0);
    check("abort_periph", 3'(bus.rst_periph_n_o), 3'd0);
    check("abort_state",  bus.seq_state_o,        3'd0);
    check("abort_cause",  3'(bus.rst_cause_o),    3'd0);
    repeat (3) @(negedge io_clk_buf);
    #1 IO_RST_N = 1'b1;

    lit("reboot35", 35, 1, 1, 1, 3'd5, 2'd0);
    wait_edge(36); #1 bus.pll_locked_i = 1'b0;
    lit("prio39", 39, 1, 1, 1, 3'd5, 2'd0); #1 bus.sw_rst_req_i = 1'b1;
    lit("prio40", 40, 0, 0, 0, 3'd1, 2'd1); #1 bus.sw_rst_req_i = 1'b0;
    lit("prio45", 45, 0, 0, 0, 3'd1, 2'd1);
    bus.pll_locked_i = 1'b1;
    repeat (20) @(negedge io_clk_buf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
